// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction-cache fills and data-cache allocate/write-back
// share one line-wide memory port, with alternating priority on simultaneous requests.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              icache_req_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    output logic              icache_ack_o,
    output logic [LINE_W-1:0] icache_rdata_o,
    input  logic              dcache_req_i,
    input  logic              dcache_wr_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic [LINE_W-1:0] dcache_wdata_i,
    output logic              dcache_ack_o,
    output logic [LINE_W-1:0] dcache_rdata_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                pick_dcache;
    logic                owner_req;

    always_comb begin
        // On a tie the data cache wins only if the instruction cache was granted last.
        pick_dcache  = dcache_req_i && (!icache_req_i || (last_grant_q == GRANT_I));
        owner_req    = (state_q == DSERVE) ? dcache_req_i : icache_req_i;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (icache_req_i || dcache_req_i) begin
                    state_d      = pick_dcache ? DSERVE : ISERVE;
                    last_grant_d = pick_dcache ? GRANT_D : GRANT_I;
                    mem_req_d    = 1'b1;
                    mem_wr_d     = pick_dcache & dcache_wr_i;
                    mem_addr_d   = pick_dcache ? dcache_addr_i : icache_addr_i;
                    mem_wdata_d  = pick_dcache ? dcache_wdata_i : '0;
                end
            end
            ISERVE, DSERVE: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (!owner_req) begin
                    // Memory still owes a completion; keep the request up and swallow it.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Completion is forwarded only while the owner still wants it.
    assign icache_ack_o   = (state_q == ISERVE) && mem_ack_i && icache_req_i;
    assign dcache_ack_o   = (state_q == DSERVE) && mem_ack_i && dcache_req_i;
    assign icache_rdata_o = mem_rdata_i;
    assign dcache_rdata_o = mem_rdata_i;

    assign mem_req_o   = mem_req_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, async-reset sequence,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam logic [AW-1:0] IA = 32'h0000_1000;
    localparam logic [AW-1:0] DA = 32'h0000_2040;
    localparam logic [LW-1:0] WD = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [LW-1:0] RD = {16{8'hA5}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          ireq, dreq, dwr, mack;
    logic [AW-1:0] iaddr, daddr;
    logic [LW-1:0] dwdata, mrdata;
    logic          iack, dack, mreq, mwr;
    logic [LW-1:0] irdata, drdata, mwdata;
    logic [AW-1:0] maddr;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk_i(clk), .rst_i(rst),
        .icache_req_i(ireq), .icache_addr_i(iaddr),
        .icache_ack_o(iack), .icache_rdata_o(irdata),
        .dcache_req_i(dreq), .dcache_wr_i(dwr), .dcache_addr_i(daddr),
        .dcache_wdata_i(dwdata), .dcache_ack_o(dack), .dcache_rdata_o(drdata),
        .mem_req_o(mreq), .mem_wr_o(mwr), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_ack_i(mack), .mem_rdata_i(mrdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected in that cycle.
    // eown: 0 = memory idle, 1 = instruction cache transaction, 2 = data cache transaction.
    typedef struct {
        logic ireq, dreq, dwr, ack;
        int   eown;
        logic ewr, eiack, edack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic i, input logic d, input logic w, input logic a,
                                input int o, input logic ew, input logic ei, input logic ed);
        vec_t v;
        v.ireq = i; v.dreq = d; v.dwr = w; v.ack = a;
        v.eown = o; v.ewr = ew; v.eiack = ei; v.edack = ed;
        return v;
    endfunction

    // Reference model state (transaction level).
    int            m_owner;
    bit            m_gone, m_last_d, m_req, m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    task automatic model_reset();
        m_owner = 0; m_gone = 0; m_last_d = 0; m_req = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0;
    endtask

    task automatic model_step();
        bit take_d, own_req;
        if (m_owner == 0) begin
            if (ireq || dreq) begin
                take_d   = dreq && (!ireq || !m_last_d);
                m_owner  = take_d ? 2 : 1;
                m_last_d = take_d;
                m_req    = 1;
                m_gone   = 0;
                m_addr   = take_d ? daddr : iaddr;
                m_wr     = take_d ? dwr : 1'b0;
                m_wdata  = take_d ? dwdata : '0;
            end
        end else begin
            own_req = (m_owner == 1) ? ireq : dreq;
            if (mack) begin
                m_owner = 0; m_req = 0; m_gone = 0;
            end else if (!own_req) begin
                m_gone = 1;
            end
        end
    endtask

    initial begin
        logic last_i, last_d, exp_i, exp_d;
        int   n_txn;

        ireq = 0; dreq = 0; dwr = 0; mack = 0;
        iaddr = IA; daddr = DA; dwdata = WD; mrdata = RD;

        // Tie after reset, write-back held, then allocate vs. pending icache.
        vecs.push_back(mk(1,1,1,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1,0, 2,1,0,0));
        vecs.push_back(mk(1,1,1,0, 2,1,0,0));
        vecs.push_back(mk(1,1,1,1, 2,1,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,1, 1,0,1,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 2,0,0,0));
        vecs.push_back(mk(0,1,0,1, 2,0,0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0));
        // Single icache read, ack four cycles after the request.
        vecs.push_back(mk(1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 1,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0));
        // Data cache withdraws at cycle 2, memory acks at cycle 6, icache waits.
        vecs.push_back(mk(0,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,1, 2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 1,0,1,0));
        // Stray ack in idle, then owner drops in the same cycle memory acks.
        vecs.push_back(mk(0,0,0,1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,1, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0));

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset_req",   mreq,   1'b0);
        check("reset_wr",    mwr,    1'b0);
        check("reset_addr",  maddr,  '0);
        check("reset_wdata", mwdata, '0);
        @(negedge clk); @(negedge clk); rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            ireq = vecs[k].ireq; dreq = vecs[k].dreq; dwr = vecs[k].dwr; mack = vecs[k].ack;
            @(negedge clk);
            $display("[TB] vec %0d ireq=%0b dreq=%0b wr=%0b ack=%0b -> mem_req=%0b addr=%h iack=%0b dack=%0b",
                     k, ireq, dreq, dwr, mack, mreq, maddr, iack, dack);
            check($sformatf("vec%0d_mem_req", k), mreq, vecs[k].eown != 0);
            check($sformatf("vec%0d_iack", k), iack, vecs[k].eiack);
            check($sformatf("vec%0d_dack", k), dack, vecs[k].edack);
            if (vecs[k].eown != 0) begin
                check($sformatf("vec%0d_addr", k), maddr, (vecs[k].eown == 2) ? DA : IA);
                check($sformatf("vec%0d_wr", k), mwr, vecs[k].ewr);
                check($sformatf("vec%0d_wdata", k), mwdata, (vecs[k].eown == 2) ? WD : '0);
            end
            if (vecs[k].eiack) check($sformatf("vec%0d_irdata", k), irdata, RD);
            if (vecs[k].edack) check($sformatf("vec%0d_drdata", k), drdata, RD);
        end

        // Asynchronous reset in the middle of a data-cache write-back.
        @(posedge clk); #1 dreq = 1; dwr = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_req", mreq, 1'b1);
        #2 rst = 1'b1;
        #1;
        $display("[TB] async reset asserted mid-transaction: mem_req=%0b", mreq);
        check("rst_async_req",   mreq,   1'b0);
        check("rst_async_wr",    mwr,    1'b0);
        check("rst_async_addr",  maddr,  '0);
        check("rst_async_wdata", mwdata, '0);
        dreq = 0; dwr = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); mack = 1; #1;
        check("stray_iack", iack, 1'b0);
        check("stray_dack", dack, 1'b0);
        @(posedge clk); #1 mack = 0;
        @(negedge clk);
        check("stray_no_req", mreq, 1'b0);
        // After reset the data cache must win a tie again.
        @(posedge clk); #1 ireq = 1; dreq = 1; dwr = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_tie_req",  mreq,  1'b1);
        check("rst_tie_addr", maddr, DA);
        #2 mack = 1; #1;
        check("rst_tie_dack", dack, 1'b1);
        check("rst_tie_iack", iack, 1'b0);
        @(posedge clk); #1 mack = 0; ireq = 0; dreq = 0;

        // Randomized traffic against the reference model.
        @(negedge clk); rst = 1'b1; model_reset();
        @(negedge clk); rst = 1'b0;
        last_i = 0; last_d = 0; n_txn = 0;
        repeat (800) begin
            @(posedge clk);
            model_step();
            #1;
            if (ireq) begin
                if (last_i || $urandom_range(0, 19) == 0) ireq = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                ireq = 1; iaddr = $urandom & 32'hFFFF_FFF0;
            end
            if (dreq) begin
                if (last_d || $urandom_range(0, 19) == 0) dreq = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                dreq = 1; dwr = 1'($urandom_range(0, 1)); daddr = $urandom & 32'hFFFF_FFF0;
                dwdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mack   = ($urandom_range(0, 3) == 0);
            mrdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            exp_i = (m_owner == 1) && !m_gone && ireq && mack;
            exp_d = (m_owner == 2) && !m_gone && dreq && mack;
            check("rnd_mem_req", mreq, m_req);
            if (m_req) begin
                check("rnd_addr",  maddr,  m_addr);
                check("rnd_wr",    mwr,    m_wr);
                check("rnd_wdata", mwdata, m_wdata);
            end
            check("rnd_iack", iack, exp_i);
            check("rnd_dack", dack, exp_d);
            if (exp_i) check("rnd_irdata", irdata, mrdata);
            if (exp_d) check("rnd_drdata", drdata, mrdata);
            if (iack || dack) begin
                n_txn++;
                $display("[TB] rnd txn %0d: %s addr=%h wr=%0b", n_txn, iack ? "icache" : "dcache", maddr, mwr);
            end
            last_i = iack;
            last_d = dack;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
